// File: rtl/circles_pkg.sv
// Shared types and widths for the circle sequencer.
package circles_pkg;

  localparam int R_W_DEF = 6;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT_DONE,
    NEXT
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debouncer and registered
// one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync0   <= btn_raw;
      r_sync1   <= r_sync0;
      // Any sample matching the accepted level restarts the run count.
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise;

endmodule

// File: rtl/circles_seq.sv
// Sequencer issuing single or concentric-sweep draw requests to circles_draw.
// Optional pre-draw screen clear is built when CIRCLES_SEQ_CLEAR_EN is defined.
module circles_seq
  import circles_pkg::*;
#(
  parameter int R_W             = R_W_DEF,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             sweep_mode,
  input  logic [R_W-1:0]   r_max,
  input  logic [3:0]       r_step,
  input  logic             draw_done,
  input  logic             clear_done,
  output logic             draw_start,
  output logic [R_W-1:0]   draw_r,
  output logic             clear_req,
  output logic             busy,
  output logic [CNT_W-1:0] circle_cnt,
  output logic             timeout_flag
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic w_unused_level;
  logic w_go;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .level     (w_unused_level),
    .rise_pulse(w_go)
  );

`ifndef CIRCLES_SEQ_CLEAR_EN
  logic w_unused_clear;
  assign w_unused_clear = clear_done;
`endif

  state_t           r_state;
  logic             r_sweep;
  logic [R_W-1:0]   r_rmax;
  logic [3:0]       r_step_l;
  logic [R_W-1:0]   r_cur;
  logic [TW-1:0]    r_tmo;
  logic             r_draw_start;
  logic [R_W-1:0]   r_draw_r;
  logic             r_clear_req;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo_flag;

  logic [3:0]     w_step1;
  logic [R_W-1:0] w_step1_ext;
  logic [R_W-1:0] w_first_r;
  logic [R_W:0]   w_nxt;
  logic           w_tmo_hit;

  // Sweep radius sum is one bit wider so an overshoot cannot wrap to a small radius.
  assign w_step1     = (r_step == 4'd0) ? 4'd1 : r_step;
  assign w_step1_ext = R_W'(w_step1);
  assign w_first_r   = (sweep_mode && (w_step1_ext <= r_max)) ? w_step1_ext : r_max;
  assign w_nxt       = {1'b0, r_cur} + (R_W + 1)'(r_step_l);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sweep      <= 1'b0;
      r_rmax       <= '0;
      r_step_l     <= '0;
      r_cur        <= '0;
      r_tmo        <= '0;
      r_draw_start <= 1'b0;
      r_draw_r     <= '0;
      r_clear_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_tmo_flag   <= 1'b0;
    end else begin
      r_draw_start <= 1'b0;
      r_clear_req  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go && (r_max != '0)) begin
            r_cnt      <= '0;
            r_tmo_flag <= 1'b0;
            r_sweep    <= sweep_mode;
            r_rmax     <= r_max;
            r_step_l   <= w_step1;
            r_cur      <= w_first_r;
            r_tmo      <= '0;
            r_busy     <= 1'b1;
`ifdef CIRCLES_SEQ_CLEAR_EN
            r_state     <= CLEAR;
            r_clear_req <= 1'b1;
`else
            r_state      <= ISSUE;
            r_draw_start <= 1'b1;
            r_draw_r     <= w_first_r;
`endif
          end
        end
`ifdef CIRCLES_SEQ_CLEAR_EN
        CLEAR: begin
          if (clear_done) begin
            r_state      <= ISSUE;
            r_draw_start <= 1'b1;
            r_draw_r     <= r_cur;
          end else if (w_tmo_hit) begin
            r_tmo_flag <= 1'b1;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
`endif
        ISSUE: begin
          r_state <= WAIT_DONE;
          r_tmo   <= '0;
        end
        // draw_done is checked before the timeout so a coincident done wins.
        WAIT_DONE: begin
          if (draw_done) begin
            r_cnt   <= sat_inc(r_cnt);
            r_state <= NEXT;
          end else if (w_tmo_hit) begin
            r_tmo_flag <= 1'b1;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        NEXT: begin
          if (r_sweep && (w_nxt <= {1'b0, r_rmax})) begin
            r_cur        <= w_nxt[R_W-1:0];
            r_draw_r     <= w_nxt[R_W-1:0];
            r_draw_start <= 1'b1;
            r_state      <= ISSUE;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign draw_start   = r_draw_start;
  assign draw_r       = r_draw_r;
  assign clear_req    = r_clear_req;
  assign busy         = r_busy;
  assign circle_cnt   = r_cnt;
  assign timeout_flag = r_tmo_flag;

endmodule

// File: tb/tb_circles_seq.sv
// Directed bench for circles_seq with a small engine model answering draw/clear requests.
module tb_circles_seq;

  localparam int D = 4;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       sweep_mode;
  logic [5:0] r_max;
  logic [3:0] r_step;
  logic       draw_done;
  logic       clear_done;
  logic       draw_start;
  logic [5:0] draw_r;
  logic       clear_req;
  logic       busy;
  logic [7:0] circle_cnt;
  logic       timeout_flag;

  int n_cmp = 0;
  int n_err = 0;
  int eng_dly = 10;
  int eng_cd = 0;
  int clr_cd = 0;
  int cyc_n = 0;
  int clr_cyc = -1;
  int st_cyc = -1;
  int starts_q[$];

  always #5 clk = ~clk;

  circles_seq #(
    .R_W            (6),
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .sweep_mode  (sweep_mode),
    .r_max       (r_max),
    .r_step      (r_step),
    .draw_done   (draw_done),
    .clear_done  (clear_done),
    .draw_start  (draw_start),
    .draw_r      (draw_r),
    .clear_req   (clear_req),
    .busy        (busy),
    .circle_cnt  (circle_cnt),
    .timeout_flag(timeout_flag)
  );

  // Engine model: done eng_dly cycles after each start (never when eng_dly==0).
  initial begin
    draw_done  = 1'b0;
    clear_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      draw_done  = 1'b0;
      clear_done = 1'b0;
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) draw_done = 1'b1;
      end
      if (clr_cd > 0) begin
        clr_cd--;
        if (clr_cd == 0) clear_done = 1'b1;
      end
      if (draw_start === 1'b1) begin
        starts_q.push_back(int'(draw_r));
        if (st_cyc < 0) st_cyc = cyc_n;
        if (eng_dly > 0) eng_cd = eng_dly;
      end
      if (clear_req === 1'b1) begin
        if (clr_cyc < 0) clr_cyc = cyc_n;
        clr_cd = 5;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    btn_raw = 1'b1;
    cyc(D + 6);
    btn_raw = 1'b0;
    cyc(D + 6);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (draw_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, draw_start, 1);
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_n"}, starts_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < starts_q.size()) chk($sformatf("%s_r%0d", tag, i), starts_q[i], exp[i]);
  endtask

  task automatic run_seq(input logic sw, input int rm, input int rs);
    sweep_mode = sw;
    r_max      = 6'(rm);
    r_step     = 4'(rs);
    starts_q.delete();
    press();
    wait_idle("seq_idle");
  endtask

  int n;

  initial begin
    rst = 1'b1; btn_raw = 1'b0; sweep_mode = 1'b0; r_max = 6'd20; r_step = 4'd0;
    cyc(3);
    chk("rst_draw_start", draw_start, 0);
    chk("rst_draw_r", draw_r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", circle_cnt, 0);
    chk("rst_tmo", timeout_flag, 0);
    chk("rst_clear_req", clear_req, 0);
    rst = 1'b0;
    cyc(3);

    // 1: bouncing button gives no go; a steady hold gives exactly one.
    starts_q.delete();
    btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(2);
      btn_raw = ~btn_raw;
    end
    chk("bounce_starts", starts_q.size(), 0);
    chk("bounce_busy", busy, 0);
    cyc(D + 6);
    btn_raw = 1'b0;
    cyc(D + 6);
    wait_idle("bounce_idle");
    chk("bounce_one_go", starts_q.size(), 1);

    // 2: single circle, exact timing from press to idle.
    sweep_mode = 1'b0; r_max = 6'd20; starts_q.delete();
    btn_raw = 1'b1;
    wait_start("single_start", n);
`ifndef CIRCLES_SEQ_CLEAR_EN
    chk("single_latency", n, D + 4);
`endif
    chk("single_r", draw_r, 20);
    cyc(11);
    chk("single_next_busy", busy, 1);
    chk("single_cnt", circle_cnt, 1);
    cyc(1);
    chk("single_busy_fall", busy, 0);
    btn_raw = 1'b0;
    cyc(D + 6);
    chk("single_starts", starts_q.size(), 1);

    // 3: sweeps; switches moved mid-sequence must not matter.
    sweep_mode = 1'b1; r_max = 6'd40; r_step = 4'd10; starts_q.delete();
    press();
    r_max = 6'd63; r_step = 4'd1; sweep_mode = 1'b0;
    wait_idle("sweep40_idle");
    chk_seq("sweep40", '{10, 20, 30, 40});
    chk("sweep40_cnt", circle_cnt, 4);
    run_seq(1'b1, 3, 0);
    chk_seq("sweep3", '{1, 2, 3});
    chk("sweep3_cnt", circle_cnt, 3);

    // 4: no wrap past r_max, and step larger than r_max.
    run_seq(1'b1, 63, 15);
    chk_seq("sweep63", '{15, 30, 45, 60});
    run_seq(1'b1, 5, 9);
    chk_seq("sweep5", '{5});
    chk("sweep5_cnt", circle_cnt, 1);

    // r_max==0 ignores go.
    run_seq(1'b0, 0, 0);
    chk("rmax0_starts", starts_q.size(), 0);

    // 5: timeout, then done coinciding with expiry wins.
    sweep_mode = 1'b0; r_max = 6'd20; eng_dly = 0;
    btn_raw = 1'b1;
    wait_start("tmo_start", n);
    cyc(T);
    chk("tmo_flag_before", timeout_flag, 0);
    chk("tmo_busy_before", busy, 1);
    cyc(1);
    chk("tmo_flag", timeout_flag, 1);
    chk("tmo_busy", busy, 0);
    btn_raw = 1'b0;
    cyc(D + 6);
    eng_dly = T;
    btn_raw = 1'b1;
    wait_start("edge_start", n);
    chk("tmo_cleared", timeout_flag, 0);
    cyc(T + 1);
    chk("edge_flag", timeout_flag, 0);
    chk("edge_cnt", circle_cnt, 1);
    chk("edge_busy", busy, 1);
    btn_raw = 1'b0;
    cyc(D + 6);
    chk("edge_idle", busy, 0);

    // 6: press while busy is dropped.
    eng_dly = 40; starts_q.delete();
    btn_raw = 1'b1; cyc(D + 6);
    btn_raw = 1'b0; cyc(D + 4);
    press();
    wait_idle("busy_press_idle");
    chk("busy_press_starts", starts_q.size(), 1);
    chk("busy_press_cnt", circle_cnt, 1);
    cyc(60);
    chk("busy_press_no_requeue", starts_q.size(), 1);

    // Asynchronous reset mid-sweep.
    eng_dly = 10; sweep_mode = 1'b1; r_max = 6'd40; r_step = 4'd10;
    press();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", circle_cnt, 0);
    chk("arst_draw_r", draw_r, 0);
    chk("arst_start", draw_start, 0);
    eng_cd = 0;
    cyc(2);
    rst = 1'b0;
    cyc(20);
    chk("post_rst_idle", busy, 0);

`ifdef CIRCLES_SEQ_CLEAR_EN
    clr_cyc = -1; st_cyc = -1;
    run_seq(1'b0, 12, 0);
    chk("clr_seen", (clr_cyc > 0), 1);
    chk("clr_to_start", st_cyc - clr_cyc, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/circles_seq.md
Name: circles_seq

Overview:
Sequencer in front of the circle-drawing engine on the FPGA board. It converts the raw centre button into a clean one-cycle go pulse and issues single-cycle start requests to the engine, with radius set from the switches. It runs either one circle or a sweep of concentric circles, waiting on the engine's done handshake between draws. It sits between the board pins and circles_draw in the top-level wrapper.

Parameters:
R_W, 6, radius width; matches the engine radius port.
DEBOUNCE_CYCLES, 1_000_000, stable cycles required to accept a button level (10 ms at 100 MHz).
TIMEOUT_CYCLES, 2_000_000, maximum cycles in WAIT_DONE before the sequence aborts.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
btn_raw  in  1  unsynchronised push button
sweep_mode  in  1  0 = single circle, 1 = concentric sweep
r_max  in  R_W  single-mode radius, or sweep upper bound
r_step  in  4  sweep increment; 0 is treated as 1
draw_done  in  1  one-cycle pulse from the engine when a circle finishes
clear_done  in  1  one-cycle pulse from the engine when the screen clear finishes
draw_start  out  1  one-cycle start pulse to the engine
draw_r  out  R_W  radius presented to the engine; held stable from draw_start until draw_done
clear_req  out  1  one-cycle clear request (see Optional Feature)
busy  out  1  high in any state other than IDLE
circle_cnt  out  8  circles completed in the current or last sequence
timeout_flag  out  1  sticky; set on timeout abort, cleared by the next accepted go

Behaviour:
- Reset value of all outputs is 0. State is IDLE. rst takes effect asynchronously at any point, including mid-sequence, and the engine handshake is abandoned.
- Button path:
  - btn_raw passes through a 2-FF synchroniser.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples at the new level.
  - go = one-cycle pulse on the debounced rising edge.
  - Total latency from a stable press to go is DEBOUNCE_CYCLES+3 cycles.
- FSM states: IDLE, CLEAR, ISSUE, WAIT_DONE, NEXT.
  - IDLE, go, r_max==0: go is ignored and the FSM stays in IDLE.
  - IDLE, go, r_max!=0: circle_cnt is cleared, timeout_flag is cleared, r_max and r_step are latched, and cur_r is set.
    - cur_r = r_max in single mode.
    - cur_r = max(r_step,1) in sweep mode.
    - If max(r_step,1) > r_max, cur_r = r_max (exactly one circle).
    - Next state is ISSUE, or CLEAR when the feature is enabled.
  - ISSUE: draw_start=1 for exactly one cycle, draw_r=cur_r, then WAIT_DONE.
  - WAIT_DONE: on draw_done, circle_cnt increments (saturating at 255) and the FSM goes to NEXT. If TIMEOUT_CYCLES elapse first, timeout_flag=1 and the FSM goes to IDLE.
  - NEXT:
    - Single mode goes to IDLE.
    - Sweep mode computes nxt = cur_r + step in R_W+1 bits (no wrap).
    - nxt <= r_max_latched: cur_r=nxt, then ISSUE.
    - Otherwise: IDLE.
- Latched values are used for the whole sequence; switch changes while busy have no effect.
- go while busy is dropped, not queued.
- draw_done outside WAIT_DONE is ignored.
- draw_done arriving in the same cycle as the timeout expiry counts as done (done wins).

Optional Feature:
Macro CIRCLES_SEQ_CLEAR_EN.
- Defined:
  - After an accepted go, the FSM enters CLEAR and pulses clear_req for one cycle.
  - It waits for clear_done, with the same TIMEOUT_CYCLES abort rule, then enters ISSUE.
- Undefined:
  - CLEAR state is absent, clear_req is tied 0, and clear_done is ignored.
- Ports are identical in both builds.

Decomposition:
- Package circles_pkg holds:
  - the state enum type;
  - localparam R_W_DEF=6;
  - localparam CNT_W=8.
- Sub-module btn_debounce (param DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, rise_pulse) contains the synchroniser, debounce counter and edge detector.
- circles_seq contains the FSM, radius arithmetic and timeout counter.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
1. Bounce btn_raw 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one go; no draw_start during the bounce.
2. Single mode, r_max=20, press; engine returns draw_done 10 cycles after start -> one draw_start with draw_r=20, circle_cnt=1, busy falls the cycle after NEXT.
3. Sweep mode, r_max=40, r_step=10 -> draw_r sequence 10,20,30,40, then IDLE, circle_cnt=4. Repeat with r_step=0, r_max=3 -> draw_r 1,2,3.
4. Sweep mode, r_max=63, r_step=15 -> draw_r 15,30,45,60 with no wrap to small values. Repeat with r_step=9, r_max=5 -> single draw_r=5.
5. Never assert draw_done -> timeout_flag=1 at cycle 50 of WAIT_DONE, return to IDLE. Next press clears timeout_flag.
6. Press during WAIT_DONE -> ignored. Assert rst mid-sweep -> all outputs 0 immediately. With CIRCLES_SEQ_CLEAR_EN: clear_req precedes the first draw_start and waits for clear_done.
